// File: rtl/aurora_rx_seq_check_pkg.sv
// aurora_rx_seq_check_pkg: shared widths, FSM states and the sequence-continuity helper
package aurora_rx_seq_check_pkg;
  localparam int SEQ_W = 32;
  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;
  function automatic logic seq_bad(input logic valid, input logic [SEQ_W-1:0] seq, input logic [SEQ_W-1:0] exp_seq);
    return valid && (seq != exp_seq);
  endfunction
endpackage

// File: rtl/rx_pkt_ram.sv
// rx_pkt_ram: simple dual-port RAM with a resettable, read-enabled output register
module rx_pkt_ram #(
  parameter int DEPTH = 512,
  parameter int W = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/aurora_rx_seq_check.sv
// aurora_rx_seq_check: store-and-forward Aurora RX packet buffer with seq-word strip and continuity check
module aurora_rx_seq_check
  import aurora_rx_seq_check_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W = 16
) (
  input  logic                     m_axis_aclk,
  input  logic                     reset,
  input  logic                     s_axis_tvalid,
  input  logic [SEQ_W-1:0]         s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [SEQ_W-1:0]         last_seq,
  output logic [CNT_W-1:0]         seq_err_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(MAX_WORDS + 1);
  state_t state;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [31:0] hold;
  logic [SEQ_W-1:0] exp_seq;
  logic [LW-1:0] len;
  logic [PW:0] level;
  logic seq_valid, full, we, re, done, dropped;
  always_comb begin
    full = (wr_ptr - rd_ptr) == PW'(DEPTH);
    we = s_axis_tvalid && state == RECV && !full && (s_axis_tlast || len < LW'(MAX_WORDS));
    re = rd_ptr != cm_ptr && (!m_axis_tvalid || m_axis_tready);
    done = s_axis_tvalid && s_axis_tlast && state != SYNC;
    dropped = done && !(state == RECV && !full);
    level = {1'b0, cm_ptr - rd_ptr} + {{PW{1'b0}}, m_axis_tvalid};
    fifo_level = level[PW] ? '1 : level[PW-1:0];
  end
  // the word held in the RAM output register still counts as unread
  always_ff @(posedge m_axis_aclk) begin
    if (reset) begin
      state <= SYNC;
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
      hold <= '0;
      len <= '0;
      exp_seq <= '0;
      seq_valid <= 1'b0;
      last_seq <= '0;
      seq_err_cnt <= '0;
      drop_cnt <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (we && s_axis_tlast) cm_ptr <= wr_ptr + 1'b1;
      if (dropped) wr_ptr <= cm_ptr;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      m_axis_tvalid <= re || (m_axis_tvalid && !m_axis_tready);
      if (done) begin
        if (seq_bad(seq_valid, s_axis_tdata, exp_seq) && !(&seq_err_cnt)) seq_err_cnt <= seq_err_cnt + 1'b1;
        exp_seq <= s_axis_tdata + 1'b1;
        last_seq <= s_axis_tdata;
        seq_valid <= 1'b1;
      end
      if (dropped && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (s_axis_tvalid) begin
        if (s_axis_tlast) state <= IDLE;
        else if (state == IDLE || we) begin
          hold <= s_axis_tdata;
          len <= state == IDLE ? LW'(1) : len + 1'b1;
          state <= RECV;
        end else if (state == RECV) state <= DROP;
      end
    end
  end
  rx_pkt_ram #(.DEPTH(DEPTH), .W(33)) u_ram (
    .clk(m_axis_aclk),
    .rst(reset),
    .we(we),
    .waddr(wr_ptr[PW-2:0]),
    .wdata({s_axis_tlast, hold}),
    .re(re),
    .raddr(rd_ptr[PW-2:0]),
    .q({m_axis_tlast, m_axis_tdata})
  );
endmodule

// File: tb/tb_aurora_rx_seq_check.sv
// tb_aurora_rx_seq_check: directed packets with a scoreboard queue popped by an output monitor
module tb_aurora_rx_seq_check;
  logic clk = 1'b0, reset = 1'b1;
  logic s_v = 1'b0, s_l = 1'b0, rdy = 1'b1;
  logic [31:0] s_d = '0;
  logic m_v, m_l;
  logic [31:0] m_d, last_seq;
  logic [15:0] seq_err_cnt, drop_cnt;
  logic [3:0] fifo_level;
  logic [32:0] exp_q[$];
  int tests = 0, fails = 0, n_out = 0;
  logic prev_stall = 1'b0;
  logic [33:0] prev = '0;

  aurora_rx_seq_check #(.DEPTH(8), .MAX_WORDS(6), .CNT_W(16)) dut (
    .m_axis_aclk(clk),
    .reset(reset),
    .s_axis_tvalid(s_v),
    .s_axis_tdata(s_d),
    .s_axis_tlast(s_l),
    .m_axis_tvalid(m_v),
    .m_axis_tdata(m_d),
    .m_axis_tlast(m_l),
    .m_axis_tready(rdy),
    .last_seq(last_seq),
    .seq_err_cnt(seq_err_cnt),
    .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("stall_hold", {m_v, m_l, m_d}, prev);
      if (m_v && rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out got %h want none", {m_l, m_d});
        end else check("out_word", {m_l, m_d}, exp_q.pop_front());
      end
      prev_stall = m_v && !rdy;
      prev = {m_v, m_l, m_d};
    end
  end

  task automatic word(input logic [31:0] d, input logic l);
    @(posedge clk); #1;
    s_v = 1'b1; s_d = d; s_l = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_v = 1'b0; s_l = 1'b0;
    end
  endtask

  task automatic pkt(input int n, input logic [31:0] base, input logic [31:0] seq, input bit keep);
    for (int i = 0; i < n; i++) begin
      logic lst;
      lst = (i == n - 1);
      word(base + i, 1'b0);
      if (keep) exp_q.push_back({lst, base + 32'(i)});
    end
    word(seq, 1'b1);
    idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || m_v); i++) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; s_v = 1'b0; s_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic sync();
    word(32'h0, 1'b1);
    idle(1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_v, 0);
    check("rst_tdata", m_d, 0);
    check("rst_tlast", m_l, 0);
    check("rst_last_seq", last_seq, 0);
    check("rst_seq_err", seq_err_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    word(32'h11, 1'b0); word(32'h22, 1'b0); word(32'h7, 1'b1); idle(1);
    pkt(2, 32'hA0, 32'h8, 1);
    drain();
    check("frag_seq_err", seq_err_cnt, 0);
    check("frag_drop", drop_cnt, 0);
    check("frag_last_seq", last_seq, 8);

    do_reset(); sync();
    pkt(2, 32'h100, 32'd5, 1);
    pkt(2, 32'h200, 32'd6, 1);
    pkt(2, 32'h300, 32'd8, 1);
    drain();
    check("gap_seq_err", seq_err_cnt, 1);
    pkt(2, 32'h400, 32'd9, 1);
    drain();
    check("resume_seq_err", seq_err_cnt, 1);
    check("resume_last_seq", last_seq, 9);
    pkt(1, 32'h500, 32'hFFFF_FFFF, 1);
    drain();
    check("pre_wrap_seq_err", seq_err_cnt, 2);
    pkt(1, 32'h600, 32'h0, 1);
    drain();
    check("wrap_seq_err", seq_err_cnt, 2);
    check("wrap_last_seq", last_seq, 0);

    do_reset(); sync();
    rdy = 1'b0;
    pkt(5, 32'h1000, 32'd1, 1);
    idle(4);
    check("stall_level5", fifo_level, 5);
    check("stall_tvalid", m_v, 1);
    pkt(5, 32'h2000, 32'd2, 0);
    check("full_drop", drop_cnt, 1);
    pkt(2, 32'h3000, 32'd3, 1);
    idle(3);
    check("stall_level7", fifo_level, 7);
    n_out = 0;
    rdy = 1'b1;
    drain();
    check("release_count", n_out, 7);
    check("release_level", fifo_level, 0);
    check("release_seq_err", seq_err_cnt, 0);

    do_reset(); sync();
    n_out = 0;
    pkt(7, 32'h4000, 32'd10, 0);
    check("long_drop", drop_cnt, 1);
    word(32'd11, 1'b1); idle(1);
    check("empty_drop", drop_cnt, 2);
    idle(4);
    check("drop_no_out", n_out, 0);
    check("drop_level", fifo_level, 0);
    pkt(1, 32'h5000, 32'd12, 1);
    drain();
    check("after_drop_seq_err", seq_err_cnt, 0);

    rdy = 1'b0;
    pkt(3, 32'h6000, 32'd13, 1);
    idle(3);
    check("pre_rst_tvalid", m_v, 1);
    word(32'h7000, 1'b0); word(32'h7001, 1'b0);
    do_reset();
    check("mid_rst_tvalid", m_v, 0);
    check("mid_rst_tdata", m_d, 0);
    check("mid_rst_tlast", m_l, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_last_seq", last_seq, 0);
    word(32'h7002, 1'b0); word(32'd14, 1'b1); idle(1);
    rdy = 1'b1;
    pkt(2, 32'h8000, 32'd15, 1);
    drain();
    check("sync_last_seq", last_seq, 15);
    check("sync_seq_err", seq_err_cnt, 0);
    check("sync_drop", drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
